// File: rtl/icon_pkg.sv
// Shared constants for the robot icon overlay: colour codes, orientations, scaling defaults
// and the two 16x16 source bitmaps (N and NE) used by the icon ROM.
package icon_pkg;

    typedef enum logic [1:0] {
        ICON_TRANSP = 2'b00,
        ICON_C1     = 2'b01,
        ICON_C2     = 2'b10,
        ICON_C3     = 2'b11
    } icon_t;

    localparam logic [2:0] ORIENT_N  = 3'd0;
    localparam logic [2:0] ORIENT_NE = 3'd1;
    localparam logic [2:0] ORIENT_E  = 3'd2;
    localparam logic [2:0] ORIENT_SE = 3'd3;
    localparam logic [2:0] ORIENT_S  = 3'd4;
    localparam logic [2:0] ORIENT_SW = 3'd5;
    localparam logic [2:0] ORIENT_W  = 3'd6;
    localparam logic [2:0] ORIENT_NW = 3'd7;

    localparam int ICON_SIZE_DEF = 16;
    localparam int X_SCALE_DEF   = 8;
    localparam int Y_SCALE_DEF   = 6;
    localparam int PIX_W_DEF     = 10;

    // addr = {base, row[3:0], col[3:0]}; base 0 is an upward arrow, base 1 a diagonal wedge
    function automatic logic [1:0] icon_pixel(input logic [8:0] addr);
        logic [3:0] r;
        logic [3:0] c;
        logic [1:0] px;
        r = addr[7:4];
        c = addr[3:0];
        if (!addr[8]) begin
            if ((r <= 4'd3) && (c >= 4'd5) && (c <= 4'd10))
                px = ICON_C3;
            else if ((c >= 4'd6) && (c <= 4'd9))
                px = ICON_C2;
            else
                px = ICON_C1;
        end else begin
            if ({1'b0, c} >= ({1'b0, r} + 5'd8))
                px = ICON_C3;
            else
                px = ICON_C1;
        end
        return px;
    endfunction

endpackage

// File: rtl/icon_generator_rom.sv
// 512x2 synchronous icon ROM: two 16x16 bitmaps, one-cycle registered read.
module icon_generator_rom
    import icon_pkg::*;
(
    input  logic       clk,
    input  logic [8:0] addr,
    output logic [1:0] dout
);

    always_ff @(posedge clk) begin
        dout <= icon_pixel(addr);
    end

endmodule

// File: rtl/icon_generator.sv
// Per-pixel robot icon overlay: frame-locked location snapshot, box test, orientation remap
// into the icon ROM, and a matching two-clock delay of video_on.
module icon_generator
    import icon_pkg::*;
#(
    parameter int ICON_SIZE = ICON_SIZE_DEF,
    parameter int X_SCALE   = X_SCALE_DEF,
    parameter int Y_SCALE   = Y_SCALE_DEF,
    parameter int PIX_W     = PIX_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [PIX_W-1:0] pixel_row,
    input  logic [PIX_W-1:0] pixel_column,
    input  logic             video_on,
    input  logic             frame_start,
    input  logic [7:0]       loc_x,
    input  logic [7:0]       loc_y,
    input  logic [7:0]       bot_info,
    output logic [1:0]       icon,
    output logic             video_on_d
);

    localparam int OW = PIX_W + 1;
    // One extra bit so col-ox cannot overflow when the origin is negative
    localparam int DW = PIX_W + 2;
    localparam logic signed [DW-1:0] BOX_HI = DW'(ICON_SIZE);
    localparam logic [OW-1:0]        HALF   = OW'(ICON_SIZE / 2);
    localparam logic [3:0]           S      = 4'd15;

    logic [6:0] r_shadow_x;
    logic [6:0] r_shadow_y;
    logic [2:0] r_shadow_orient;

    logic       r_in_box1;
    logic [3:0] r_dc1;
    logic [3:0] r_dr1;
    logic [2:0] r_orient1;
    logic       r_vid1;

    logic       r_in_box2;
    logic       r_vid2;

    logic [OW-1:0]        w_cx;
    logic [OW-1:0]        w_cy;
    logic signed [OW-1:0] w_ox;
    logic signed [OW-1:0] w_oy;
    logic signed [DW-1:0] w_dc_full;
    logic signed [DW-1:0] w_dr_full;
    logic                 w_in_box;
    logic [3:0]           w_r;
    logic [3:0]           w_c;
    logic [8:0]           w_rom_addr;
    logic [1:0]           w_rom_data;
    logic                 w_unused;

    assign w_unused = ^{loc_x[7], loc_y[7], bot_info[7:3]};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_shadow_x      <= '0;
            r_shadow_y      <= '0;
            r_shadow_orient <= '0;
        end else if (frame_start) begin
            r_shadow_x      <= loc_x[6:0];
            r_shadow_y      <= loc_y[6:0];
            r_shadow_orient <= bot_info[2:0];
        end
    end

    assign w_cx = OW'(int'(r_shadow_x) * X_SCALE);
    assign w_cy = OW'(int'(r_shadow_y) * Y_SCALE);
    assign w_ox = $signed(w_cx - HALF);
    assign w_oy = $signed(w_cy - HALF);

    assign w_dc_full = $signed({2'b00, pixel_column}) - $signed({w_ox[OW-1], w_ox});
    assign w_dr_full = $signed({2'b00, pixel_row})    - $signed({w_oy[OW-1], w_oy});
    assign w_in_box  = !w_dc_full[DW-1] && (w_dc_full < BOX_HI) &&
                       !w_dr_full[DW-1] && (w_dr_full < BOX_HI);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_in_box1 <= 1'b0;
            r_dc1     <= '0;
            r_dr1     <= '0;
            r_orient1 <= '0;
            r_vid1    <= 1'b0;
            r_in_box2 <= 1'b0;
            r_vid2    <= 1'b0;
        end else begin
            r_in_box1 <= w_in_box;
            r_dc1     <= w_dc_full[3:0];
            r_dr1     <= w_dr_full[3:0];
            r_orient1 <= r_shadow_orient;
            r_vid1    <= video_on;
            r_in_box2 <= r_in_box1;
            r_vid2    <= r_vid1;
        end
    end

    // Quarter-turn clockwise rotations of the screen-space offset back into bitmap space
    always_comb begin
        w_r = r_dr1;
        w_c = r_dc1;
        case (r_orient1[2:1])
            2'd1: begin
                w_r = S - r_dc1;
                w_c = r_dr1;
            end
            2'd2: begin
                w_r = S - r_dr1;
                w_c = S - r_dc1;
            end
            2'd3: begin
                w_r = r_dc1;
                w_c = S - r_dr1;
            end
            default: begin
                w_r = r_dr1;
                w_c = r_dc1;
            end
        endcase
    end

    assign w_rom_addr = {r_orient1[0], w_r, w_c};

    icon_generator_rom u_rom (
        .clk  (clk),
        .addr (w_rom_addr),
        .dout (w_rom_data)
    );

    assign icon       = (r_in_box2 && r_vid2) ? w_rom_data : ICON_TRANSP;
    assign video_on_d = r_vid2;

endmodule

// File: tb/tb_icon_generator.sv
// Directed bench for icon_generator: reset, placement, rotation, clipping, tearing and blanking.
module tb_icon_generator;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [9:0] pixel_row;
    logic [9:0] pixel_column;
    logic       video_on;
    logic       frame_start;
    logic [7:0] loc_x;
    logic [7:0] loc_y;
    logic [7:0] bot_info;
    logic [1:0] icon;
    logic       video_on_d;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    icon_generator dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pixel_row    (pixel_row),
        .pixel_column (pixel_column),
        .video_on     (video_on),
        .frame_start  (frame_start),
        .loc_x        (loc_x),
        .loc_y        (loc_y),
        .bot_info     (bot_info),
        .icon         (icon),
        .video_on_d   (video_on_d)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic snap(input logic [7:0] x, input logic [7:0] y, input logic [7:0] o);
        @(negedge clk);
        loc_x       = x;
        loc_y       = y;
        bot_info    = o;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic pix_chk(input string tag, input logic [9:0] row, input logic [9:0] col,
                           input logic [1:0] exp);
        @(negedge clk);
        pixel_row    = row;
        pixel_column = col;
        video_on     = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_val(tag, {30'd0, icon}, {30'd0, exp});
    endtask

    logic [7:0] pat;

    initial begin
        reset_n      = 1'b0;
        video_on     = 1'b1;
        frame_start  = 1'b0;
        loc_x        = 8'd0;
        loc_y        = 8'd0;
        bot_info     = 8'd0;
        pixel_row    = 10'd0;
        pixel_column = 10'd0;

        repeat (3) begin
            @(negedge clk);
            check_val("rst_icon", {30'd0, icon}, 32'd0);
            check_val("rst_vid", {31'd0, video_on_d}, 32'd0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        check_val("rel1_vid", {31'd0, video_on_d}, 32'd0);
        check_val("rel1_icon", {30'd0, icon}, 32'd0);
        @(negedge clk);
        check_val("rel2_vid", {31'd0, video_on_d}, 32'd1);
        check_val("rel2_icon", {30'd0, icon}, 32'd2);

        // origin (504,376)
        snap(8'd64, 8'd64, 8'd0);
        pix_chk("place_c503", 10'd384, 10'd503, 2'b00);
        pix_chk("place_c504", 10'd384, 10'd504, 2'b01);
        pix_chk("place_c510", 10'd384, 10'd510, 2'b10);
        pix_chk("place_c513", 10'd384, 10'd513, 2'b10);
        pix_chk("place_c514", 10'd384, 10'd514, 2'b01);
        pix_chk("place_c519", 10'd384, 10'd519, 2'b01);
        pix_chk("place_c520", 10'd384, 10'd520, 2'b00);
        pix_chk("place_tip",  10'd376, 10'd509, 2'b11);
        pix_chk("place_r375", 10'd375, 10'd510, 2'b00);
        pix_chk("place_r392", 10'd392, 10'd510, 2'b00);

        snap(8'd192, 8'd192, 8'd0);
        pix_chk("msb_in",  10'd384, 10'd504, 2'b01);
        pix_chk("msb_out", 10'd384, 10'd503, 2'b00);

        snap(8'd64, 8'd64, 8'd2);
        pix_chk("rot1_hit", 10'd381, 10'd519, 2'b11);
        pix_chk("rot1_tip", 10'd376, 10'd509, 2'b01);
        snap(8'd64, 8'd64, 8'd4);
        pix_chk("rot2_hit", 10'd391, 10'd514, 2'b11);
        snap(8'd64, 8'd64, 8'd6);
        pix_chk("rot3_hit", 10'd386, 10'd504, 2'b11);
        snap(8'd64, 8'd64, 8'd1);
        pix_chk("ne_hit",  10'd376, 10'd519, 2'b11);
        pix_chk("ne_miss", 10'd391, 10'd504, 2'b01);
        snap(8'd64, 8'd64, 8'h09);
        pix_chk("ne_hibits", 10'd376, 10'd519, 2'b11);
        snap(8'd64, 8'd64, 8'd3);
        pix_chk("ne_rot1_a", 10'd376, 10'd519, 2'b01);
        pix_chk("ne_rot1_b", 10'd391, 10'd519, 2'b11);

        // origin (-8,-8)
        snap(8'd0, 8'd0, 8'd0);
        pix_chk("clip_00",    10'd0,   10'd0,    2'b10);
        pix_chk("clip_c7",    10'd0,   10'd7,    2'b01);
        pix_chk("clip_c8",    10'd0,   10'd8,    2'b00);
        pix_chk("clip_r7",    10'd7,   10'd0,    2'b10);
        pix_chk("clip_r8",    10'd8,   10'd0,    2'b00);
        pix_chk("clip_c1016", 10'd0,   10'd1016, 2'b00);
        pix_chk("clip_c1023", 10'd0,   10'd1023, 2'b00);
        pix_chk("clip_r767",  10'd767, 10'd0,    2'b00);

        // origin (1008,754)
        snap(8'd127, 8'd127, 8'd0);
        pix_chk("edge_c1023", 10'd762, 10'd1023, 2'b01);
        pix_chk("edge_c1007", 10'd762, 10'd1007, 2'b00);

        snap(8'd64, 8'd64, 8'd0);
        loc_x = 8'd10;
        pix_chk("tear_old", 10'd384, 10'd504, 2'b01);
        pix_chk("tear_new", 10'd384, 10'd72,  2'b00);
        snap(8'd10, 8'd64, 8'd0);
        pix_chk("tear_moved", 10'd384, 10'd72,  2'b01);
        pix_chk("tear_gone",  10'd384, 10'd504, 2'b00);

        snap(8'd64, 8'd64, 8'd0);
        pat          = 8'b0010_1101;
        pixel_row    = 10'd384;
        pixel_column = 10'd510;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                check_val("blank_vid", {31'd0, video_on_d}, {31'd0, pat[i-2]});
                check_val("blank_icon", {30'd0, icon}, pat[i-2] ? 32'd2 : 32'd0);
            end
            video_on = (i < 8) ? pat[i] : 1'b0;
        end

        @(negedge clk);
        video_on     = 1'b1;
        pixel_row    = 10'd384;
        pixel_column = 10'd504;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check_val("mid_rst_icon", {30'd0, icon}, 32'd0);
        check_val("mid_rst_vid", {31'd0, video_on_d}, 32'd0);
        reset_n = 1'b1;
        pix_chk("post_rst_old", 10'd384, 10'd504, 2'b00);
        pix_chk("post_rst_org", 10'd0,   10'd0,   2'b10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
